pad_ctrl_bank: RTL and testbench
================================

# pad_ctrl_bank

Parametrised, run-time configurable bidirectional pad controller for the CPU system top level. It replaces hard-tied pad direction and pull settings with per-pin OE/IE/PU/PD registers written over a valid/ready config port. It applies break-before-make sequencing on direction changes, synchronises pad inputs, and records sticky per-pin input-change flags. It sits between the pad ring and the core, alongside the clock, reset and data pads.

## Interface
- N_PINS, 15, number of bidirectional pins (1..32)
- TURN_CYCLES, 2, dead cycles between input release and output enable (>=1)
- SYNC_STAGES, 2, input synchroniser depth (>=2)

- pad_clk  in  1  single clock, all logic rising-edge
- pad_rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when valid&ready
- cfg_sel  in  2  target register: 0=OE, 1=IE, 2=PU, 3=PD
- cfg_wdata  in  N_PINS  new full-vector value for selected register
- core_out  in  N_PINS  data from core to pads
- pad_in  in  N_PINS  raw asynchronous data from pads
- core_in  out  N_PINS  synchronised, IE-gated pad data to core
- pad_out  out  N_PINS  registered data to pads
- oe_bidir / ie_bidir / pu_bidir / pd_bidir  out  N_PINS each  pad control vectors
- edge_flags  out  N_PINS  sticky "input changed" flags
- edge_clr  in  N_PINS  per-bit clear for edge_flags
- busy  out  1  turnaround in progress (== ~cfg_ready)

## Operation
- Reset values: oe=0, ie=all 1, pu=0, pd=0, pad_out=0, core_in=0, sync chain=0, edge_flags=0, cfg_ready=1, busy=0, FSM=IDLE.
- FSM states: IDLE, TURN. The reset input is asynchronous and returns all state to its reset values immediately, including mid-TURN.
- IE, PU and PD writes (accepted in IDLE): the register takes cfg_wdata. The FSM stays in IDLE.
- PU/PD exclusivity: on a PU write, pd &= ~cfg_wdata. On a PD write, pu &= ~cfg_wdata. The written field wins. pu&pd is never nonzero.
- OE write, rising = cfg_wdata & ~oe:
  - If rising==0: oe takes cfg_wdata directly (input-going pins release immediately). The FSM stays in IDLE.
  - If rising!=0:
    - oe becomes oe & cfg_wdata.
    - ie &= ~rising.
    - The FSM latches cfg_wdata into a pending register and enters TURN with its counter at TURN_CYCLES.
    - cfg_ready goes low.
- TURN: the counter decrements each cycle. At 1, oe takes the pending value, the FSM returns to IDLE and cfg_ready goes high. No writes are accepted in TURN; the requester holds cfg_valid and its data.
- ie is not re-enabled automatically; software writes IE.
- pad_out is registered from core_out every cycle, independent of oe.
- Input path:
  - pad_in passes through a SYNC_STAGES flop chain.
  - core_in = sync_out & ie, registered.
  - A pin with ie=0 reads 0.
- Edge flags:
  - flag[i] sets when core_in[i] differs from its previous-cycle value.
  - edge_clr[i] clears it. If set and clear occur in the same cycle, set wins.
  - Flags are sticky otherwise.

## Timing
- Write accepted at edge k: IE/PU/PD and the immediate OE result are visible after edge k.
- OE with rising bits:
  - Partial oe and cleared ie are visible after edge k.
  - The final oe is visible after edge k+TURN_CYCLES.
  - cfg_ready is low for cycles k+1..k+TURN_CYCLES and high after edge k+TURN_CYCLES.
- A back-to-back write in the cycle after a non-OE write is accepted (full throughput in IDLE).
- pad_in change sampled at edge j: sync_out changes after edge j+SYNC_STAGES-1, core_in after edge j+SYNC_STAGES, and edge_flag after edge j+SYNC_STAGES+1.
- core_out to pad_out latency is 1 cycle.
- cfg_valid deasserted without acceptance is legal and has no effect.

## Test plan
- Reset mid-TURN: issue an OE write 0x0003, assert pad_rst_n low at cycle k+1 -> oe=0, ie=0x7FFF, cfg_ready=1 immediately (asynchronously). After release, FSM=IDLE.
- Break-before-make (TURN_CYCLES=2), oe=0x0001, ie=0x7FFF, write OE=0x0006 at edge k -> after k: oe=0x0000, ie=0x7FF9, cfg_ready=0. After k+1: unchanged. After k+2: oe=0x0006, cfg_ready=1.
- OE clear-only write, oe=0x00F0, write OE=0x0030 -> oe=0x0030 after one edge, cfg_ready stays 1.
- Pull conflict: write PU=0x000F, then PD=0x0003 -> pu=0x000C, pd=0x0003. Then write PU=0x0001 -> pu=0x0001, pd=0x0002.
- Input sync and flags (SYNC_STAGES=2):
  - pad_in[5] rises before edge j -> core_in[5]=1 after edge j+2, edge_flags[5]=1 after edge j+3.
  - Pulse edge_clr[5] -> flag clears.
  - Clear coincident with a new toggle -> flag stays 1.
- IE gating: ie[5] written 0 with pad_in[5]=1 -> core_in[5]=0 one edge later, and edge_flags[5] sets from the falling transition.

Source files
------------

// File: rtl/pad_ctrl_bank_if.sv
// pad_ctrl_bank_if: valid/ready configuration write port for the pad control bank.
interface pad_ctrl_bank_if #(parameter int N_PINS = 15) ();
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_sel;
    logic [N_PINS-1:0] cfg_wdata;
    modport master (output cfg_valid, cfg_sel, cfg_wdata, input cfg_ready);
    modport slave (input cfg_valid, cfg_sel, cfg_wdata, output cfg_ready);
endinterface

// File: rtl/pad_ctrl_bank.sv
// pad_ctrl_bank: per-pin OE/IE/PU/PD registers with break-before-make OE turnaround,
// synchronised IE-gated pad inputs and sticky input-change flags.
module pad_ctrl_bank #(
    parameter int N_PINS      = 15,
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic              pad_clk,
    input  logic              pad_rst_n,
    pad_ctrl_bank_if.slave    cfg,
    input  logic [N_PINS-1:0] core_out,
    input  logic [N_PINS-1:0] pad_in,
    input  logic [N_PINS-1:0] edge_clr,
    output logic [N_PINS-1:0] core_in,
    output logic [N_PINS-1:0] pad_out,
    output logic [N_PINS-1:0] oe_bidir,
    output logic [N_PINS-1:0] ie_bidir,
    output logic [N_PINS-1:0] pu_bidir,
    output logic [N_PINS-1:0] pd_bidir,
    output logic [N_PINS-1:0] edge_flags,
    output logic              busy
);
    localparam int CW = $clog2(TURN_CYCLES + 1);

    typedef enum logic {IDLE, TURN} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [N_PINS-1:0] oe_n, ie_n, pu_n, pd_n, pend, pend_n, rising, core_prev;
    logic [N_PINS-1:0] sync [SYNC_STAGES];

    assign cfg.cfg_ready = (state == IDLE);
    assign busy          = (state != IDLE);
    assign rising        = cfg.cfg_wdata & ~oe_bidir;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        oe_n    = oe_bidir;
        ie_n    = ie_bidir;
        pu_n    = pu_bidir;
        pd_n    = pd_bidir;
        pend_n  = pend;
        if (state == TURN) begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state_n = IDLE;
                oe_n    = pend;
            end
        end else if (cfg.cfg_valid) begin
            case (cfg.cfg_sel)
                2'd0: begin
                    if (rising == '0) begin
                        oe_n = cfg.cfg_wdata;
                    end else begin
                        // drivers that stay on keep driving; new drivers wait out the turnaround
                        oe_n    = oe_bidir & cfg.cfg_wdata;
                        ie_n    = ie_bidir & ~rising;
                        pend_n  = cfg.cfg_wdata;
                        cnt_n   = CW'(TURN_CYCLES);
                        state_n = TURN;
                    end
                end
                2'd1: ie_n = cfg.cfg_wdata;
                2'd2: begin
                    pu_n = cfg.cfg_wdata;
                    pd_n = pd_bidir & ~cfg.cfg_wdata;
                end
                default: begin
                    pd_n = cfg.cfg_wdata;
                    pu_n = pu_bidir & ~cfg.cfg_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge pad_clk or negedge pad_rst_n) begin
        if (!pad_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            oe_bidir <= '0;
            ie_bidir <= '1;
            pu_bidir <= '0;
            pd_bidir <= '0;
            pend     <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            oe_bidir <= oe_n;
            ie_bidir <= ie_n;
            pu_bidir <= pu_n;
            pd_bidir <= pd_n;
            pend     <= pend_n;
        end
    end

    always_ff @(posedge pad_clk or negedge pad_rst_n) begin
        if (!pad_rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
            pad_out    <= '0;
            core_in    <= '0;
            core_prev  <= '0;
            edge_flags <= '0;
        end else begin
            sync[0] <= pad_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            pad_out    <= core_out;
            core_in    <= sync[SYNC_STAGES-1] & ie_bidir;
            core_prev  <= core_in;
            // a fresh change beats a coincident clear
            edge_flags <= (edge_flags & ~edge_clr) | (core_in ^ core_prev);
        end
    end
endmodule

// File: tb/tb_pad_ctrl_bank.sv
// tb_pad_ctrl_bank: directed vector table, hand-written corner sequences and random
// stimulus checked against a behavioural model of the pad bank.
module tb_pad_ctrl_bank;
    localparam int N = 15, TC = 2, SS = 2;
    localparam logic [N-1:0] ALL = '1;

    logic clk = 0, rst_n = 0;
    logic [N-1:0] core_out, pad_in, edge_clr, core_in, pad_out, oe, ie, pu, pd, flags;
    logic busy;
    int passed = 0, total = 0;

    pad_ctrl_bank_if #(.N_PINS(N)) cfg ();

    pad_ctrl_bank #(.N_PINS(N), .TURN_CYCLES(TC), .SYNC_STAGES(SS)) dut (
        .pad_clk(clk), .pad_rst_n(rst_n), .cfg(cfg.slave), .core_out(core_out), .pad_in(pad_in),
        .edge_clr(edge_clr), .core_in(core_in), .pad_out(pad_out), .oe_bidir(oe), .ie_bidir(ie),
        .pu_bidir(pu), .pd_bidir(pd), .edge_flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;

    // behavioural model
    logic [N-1:0] m_oe, m_ie, m_pu, m_pd, m_pend, m_pout, m_core, m_prev, m_flags;
    int m_turn;
    logic [N-1:0] hist[$];

    function automatic void m_reset();
        m_oe = '0; m_ie = ALL; m_pu = '0; m_pd = '0; m_pend = '0; m_pout = '0;
        m_core = '0; m_prev = '0; m_flags = '0; m_turn = 0;
        hist.delete();
    endfunction

    function automatic void m_edge();
        logic [N-1:0] sout, r, w;
        sout = (hist.size() >= SS) ? hist[SS-1] : '0;
        hist.push_front(pad_in);
        if (hist.size() > SS) void'(hist.pop_back());
        m_flags = (m_flags & ~edge_clr) | (m_core ^ m_prev);
        m_prev  = m_core;
        m_core  = sout & m_ie;
        m_pout  = core_out;
        w = cfg.cfg_wdata;
        if (m_turn > 0) begin
            m_turn--;
            if (m_turn == 0) m_oe = m_pend;
        end else if (cfg.cfg_valid) begin
            if (cfg.cfg_sel == 2'd0) begin
                r = w & ~m_oe;
                if (r == '0) m_oe = w;
                else begin
                    m_oe = m_oe & w; m_ie = m_ie & ~r; m_pend = w; m_turn = TC;
                end
            end else if (cfg.cfg_sel == 2'd1) m_ie = w;
            else if (cfg.cfg_sel == 2'd2) begin m_pu = w; m_pd = m_pd & ~w; end
            else begin m_pd = w; m_pu = m_pu & ~w; end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_all();
        check("oe", 32'(oe), 32'(m_oe));
        check("ie", 32'(ie), 32'(m_ie));
        check("pu", 32'(pu), 32'(m_pu));
        check("pd", 32'(pd), 32'(m_pd));
        check("ready", 32'(cfg.cfg_ready), 32'(m_turn == 0));
        check("busy", 32'(busy), 32'(m_turn != 0));
        check("pad_out", 32'(pad_out), 32'(m_pout));
        check("core_in", 32'(core_in), 32'(m_core));
        check("flags", 32'(flags), 32'(m_flags));
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [N-1:0] w);
        cfg.cfg_valid = v; cfg.cfg_sel = s; cfg.cfg_wdata = w;
    endtask

    typedef struct {
        logic v; logic [1:0] sel; logic [N-1:0] wd, oe, ie, pu, pd; logic rdy;
    } vec_t;
    vec_t tbl[17];

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 15'h0001, 15'h0000, 15'h7FFE, 15'h0000, 15'h0000, 1'b0};
        tbl[1]  = '{1'b1, 2'd0, 15'h0001, 15'h0000, 15'h7FFE, 15'h0000, 15'h0000, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 15'h0001, 15'h0001, 15'h7FFE, 15'h0000, 15'h0000, 1'b1};
        tbl[3]  = '{1'b1, 2'd1, 15'h7FFF, 15'h0001, 15'h7FFF, 15'h0000, 15'h0000, 1'b1};
        tbl[4]  = '{1'b1, 2'd0, 15'h0006, 15'h0000, 15'h7FF9, 15'h0000, 15'h0000, 1'b0};
        tbl[5]  = '{1'b1, 2'd0, 15'h0006, 15'h0000, 15'h7FF9, 15'h0000, 15'h0000, 1'b0};
        tbl[6]  = '{1'b1, 2'd0, 15'h0006, 15'h0006, 15'h7FF9, 15'h0000, 15'h0000, 1'b1};
        tbl[7]  = '{1'b1, 2'd0, 15'h00F6, 15'h0006, 15'h7F09, 15'h0000, 15'h0000, 1'b0};
        tbl[8]  = '{1'b1, 2'd0, 15'h00F6, 15'h0006, 15'h7F09, 15'h0000, 15'h0000, 1'b0};
        tbl[9]  = '{1'b1, 2'd0, 15'h00F6, 15'h00F6, 15'h7F09, 15'h0000, 15'h0000, 1'b1};
        tbl[10] = '{1'b1, 2'd0, 15'h00F0, 15'h00F0, 15'h7F09, 15'h0000, 15'h0000, 1'b1};
        tbl[11] = '{1'b1, 2'd0, 15'h0030, 15'h0030, 15'h7F09, 15'h0000, 15'h0000, 1'b1};
        tbl[12] = '{1'b1, 2'd2, 15'h000F, 15'h0030, 15'h7F09, 15'h000F, 15'h0000, 1'b1};
        tbl[13] = '{1'b1, 2'd3, 15'h0003, 15'h0030, 15'h7F09, 15'h000C, 15'h0003, 1'b1};
        tbl[14] = '{1'b1, 2'd2, 15'h0001, 15'h0030, 15'h7F09, 15'h0001, 15'h0002, 1'b1};
        tbl[15] = '{1'b0, 2'd3, 15'h7FFF, 15'h0030, 15'h7F09, 15'h0001, 15'h0002, 1'b1};
        tbl[16] = '{1'b1, 2'd1, 15'h7FFF, 15'h0030, 15'h7FFF, 15'h0001, 15'h0002, 1'b1};

        drive(0, 0, '0);
        core_out = '0; pad_in = '0; edge_clr = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_oe", 32'(oe), 0);
        check("rst_ie", 32'(ie), 32'h7FFF);
        check("rst_ready", 32'(cfg.cfg_ready), 1);
        check("rst_flags", 32'(flags), 0);
        #3 rst_n = 1;
        @(negedge clk);

        // asynchronous reset in the middle of a turnaround
        drive(1, 0, 15'h0003);
        tick();
        check("turn_ie", 32'(ie), 32'h7FFC);
        check("turn_ready", 32'(cfg.cfg_ready), 0);
        #2 rst_n = 0;
        #1;
        check("arst_oe", 32'(oe), 0);
        check("arst_ie", 32'(ie), 32'h7FFF);
        check("arst_ready", 32'(cfg.cfg_ready), 1);
        check("arst_busy", 32'(busy), 0);
        m_reset();
        drive(0, 0, '0);
        #2 rst_n = 1;
        tick();
        check("post_rst_ready", 32'(cfg.cfg_ready), 1);

        // directed config vectors
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].sel, tbl[i].wd);
            tick();
            check($sformatf("vec%0d_oe", i), 32'(oe), 32'(tbl[i].oe));
            check($sformatf("vec%0d_ie", i), 32'(ie), 32'(tbl[i].ie));
            check($sformatf("vec%0d_pu", i), 32'(pu), 32'(tbl[i].pu));
            check($sformatf("vec%0d_pd", i), 32'(pd), 32'(tbl[i].pd));
            check($sformatf("vec%0d_rdy", i), 32'(cfg.cfg_ready), 32'(tbl[i].rdy));
        end
        drive(0, 0, '0);

        // synchroniser latency and sticky flags
        pad_in = 15'h0020;
        tick(); tick();
        check("sync_core_early", 32'(core_in[5]), 0);
        tick();
        check("sync_core", 32'(core_in[5]), 1);
        check("sync_flag_early", 32'(flags[5]), 0);
        tick();
        check("sync_flag", 32'(flags[5]), 1);
        tick();
        check("flag_sticky", 32'(flags[5]), 1);
        edge_clr = 15'h0020;
        tick();
        edge_clr = '0;
        check("flag_clr", 32'(flags[5]), 0);
        pad_in = '0;
        tick(); tick(); tick();
        edge_clr = 15'h0020;
        tick();
        edge_clr = '0;
        check("flag_set_wins", 32'(flags[5]), 1);

        // IE gating produces a falling transition
        pad_in = 15'h0020;
        repeat (4) tick();
        edge_clr = ALL;
        tick();
        edge_clr = '0;
        check("gate_pre_core", 32'(core_in[5]), 1);
        drive(1, 1, 15'h7FDF);
        tick();
        drive(0, 0, '0);
        tick();
        check("gate_core", 32'(core_in[5]), 0);
        tick();
        check("gate_flag", 32'(flags[5]), 1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom), N'($urandom));
            core_out = N'($urandom);
            if ($urandom_range(0, 3) == 0) pad_in = pad_in ^ N'($urandom);
            edge_clr = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            tick();
            check("pu_pd_excl", 32'(pu & pd), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
